// File: rtl/div_seq_if.sv
// Request/response bundle for the sequential divider.
// Master drives the request; slave returns status and the result.
interface div_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, op, a, b,
    input  busy, done, result, div_by_zero, overflow
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, div_by_zero, overflow
  );
endinterface

// File: rtl/div_seq.sv
// Restoring shift-subtract divider for signed/unsigned DIV and REM.
// Produces one quotient bit per cycle; zero-divisor and signed-overflow cases finish on the accept edge.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  div_seq_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] remQ_q;
  logic [WIDTH-1:0] dividend_q;
  logic [WIDTH-1:0] divisor_q;
  logic             negQuo_q;
  logic             negRem_q;
  logic             remOp_q;
  logic [WIDTH-1:0] result_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;
  logic             ovf_q;

  logic             isSigned;
  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magB;
  logic             divZero;
  logic             sgnOvf;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] quoSigned;
  logic [WIDTH-1:0] remSigned;
  logic [WIDTH-1:0] final_d;

  // Operand conditioning at accept time, plus one restoring step of the
  // datapath. The dividend register shifts left and collects quotient bits.
  always_comb begin
    isSigned  = ~bus.op[0];
    magA      = (isSigned && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    magB      = (isSigned && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    divZero   = (bus.b == '0);
    sgnOvf    = isSigned && (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.b == '1);
    shifted   = {remQ_q, dividend_q[WIDTH-1]};
    trial     = shifted - {1'b0, divisor_q};
    borrow    = trial[WIDTH];
    rem_d     = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_d     = {dividend_q[WIDTH-2:0], ~borrow};
    quoSigned = negQuo_q ? -quo_d : quo_d;
    remSigned = negRem_q ? -rem_d : rem_d;
    final_d   = remOp_q ? remSigned : quoSigned;
  end

  // Control FSM and datapath registers; status outputs are registered here
  // so they change only with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      remQ_q     <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      negQuo_q   <= 1'b0;
      negRem_q   <= 1'b0;
      remOp_q    <= 1'b0;
      result_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            remOp_q <= bus.op[1];
            busy_q  <= 1'b1;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            if (divZero) begin
              result_q <= bus.op[1] ? bus.a : '1;
              dbz_q    <= 1'b1;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else if (sgnOvf) begin
              result_q <= bus.op[1] ? '0 : bus.a;
              ovf_q    <= 1'b1;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              remQ_q     <= '0;
              dividend_q <= magA;
              divisor_q  <= magB;
              negQuo_q   <= isSigned && (bus.a[WIDTH-1] != bus.b[WIDTH-1]);
              negRem_q   <= isSigned && bus.a[WIDTH-1];
              state_q    <= CALC;
            end
          end
        end
        CALC: begin
          remQ_q     <= rem_d;
          dividend_q <= quo_d;
          if (cnt_q == LAST) begin
            cnt_q    <= '0;
            result_q <= final_d;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  00 DIV (signed), 01 DIVU, 10 REM (signed), 11 REMU.
REQ-006 SHALL have port a  input  WIDTH  dividend, sampled with start.
REQ-007 SHALL have port b  input  WIDTH  divisor, sampled with start.
REQ-008 SHALL have port busy  output  1  high in CALC and DONE.
REQ-009 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-010 SHALL have port result  output  WIDTH  quotient (DIV/DIVU) or remainder (REM/REMU).
REQ-011 SHALL have port div_by_zero  output  1  flag for the completed operation.
REQ-012 SHALL have port overflow  output  1  signed-overflow flag for the completed operation.

Function
REQ-013 SHALL implement states IDLE, CALC, DONE; busy = (state != IDLE), done = (state == DONE).
REQ-014 SHALL accept a request on a rising edge with state IDLE and start=1, capturing op, a, b; start SHALL be ignored in CALC and DONE, with no effect on the operation in flight.
REQ-015 SHALL, for signed ops, divide operand magnitudes; quotient negated when a[WIDTH-1] != b[WIDTH-1]; remainder takes the sign of a.
REQ-016 SHALL use restoring shift-subtract with one quotient bit per cycle, via a WIDTH+1-bit trial subtraction (borrow = MSB); no combinational divider.
REQ-017 SHALL, normal case: IDLE->CALC on accept edge, stay in CALC exactly WIDTH cycles (cycle counter 0..WIDTH-1, wrapping to 0), then ->DONE; done high in the cycle after edge WIDTH+1 counted from accept (edge 33 at WIDTH=32).
REQ-018 SHALL, divisor zero: skip CALC, IDLE->DONE on accept edge; quotient = all ones, remainder = a, div_by_zero=1; applies to all four ops.
REQ-019 SHALL, signed overflow (op DIV/REM, a = 1 followed by WIDTH-1 zeros, b = all ones): skip CALC, IDLE->DONE on accept edge; quotient = a, remainder = 0, overflow=1.
REQ-020 SHALL go DONE->IDLE unconditionally after one cycle; a start asserted during DONE is not accepted.
REQ-021 SHALL hold result, div_by_zero, overflow stable from DONE entry until the next accepted start; flags cleared at the accept edge of the next request.
REQ-022 SHALL never assert div_by_zero and overflow together; divisor-zero check takes priority.
REQ-023 SHALL allow back-to-back requests: start high in the first IDLE cycle after DONE is accepted.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously force state IDLE, counter 0, busy=0, done=0, result=0, div_by_zero=0, overflow=0.
REQ-025 SHALL abort any operation in progress on reset; no done pulse for it; the first request after rst_n rises is handled normally.

Verification
REQ-026 SHALL check DIVU a=100 b=7 -> done exactly 33 edges after accept, result=14; REMU same operands -> result=2, flags 0.
REQ-027 SHALL check DIV a=0xFFFFFFF9 (-7) b=2 -> result=0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1); DIV a=7 b=0xFFFFFFFE -> 0xFFFFFFFD.
REQ-028 SHALL check DIVU a=5 b=0 -> done in the cycle after accept, result=0xFFFFFFFF, div_by_zero=1; REM a=0xFFFFFFF9 b=0 -> result=0xFFFFFFF9, div_by_zero=1.
REQ-029 SHALL check DIV a=0x80000000 b=0xFFFFFFFF -> result=0x80000000, overflow=1, latency 1; REM same -> result=0, overflow=1.
REQ-030 SHALL check start pulsed with new operands at CALC cycle 10 and during DONE -> ignored, original result delivered, exactly one done pulse.
REQ-031 SHALL check rst_n dropped mid-clock at CALC cycle 20 -> outputs zero immediately, no done; after release DIVU 0xFFFFFFFF/0x10 -> 0x0FFFFFFF.
